// File: rtl/tttv2.sv
// ---------------------------------------------------------------------------
// tttv2 : 3x3 tic-tac-toe referee
//
// Stores the board, enforces legal moves and strict turn alternation, and
// continuously decodes the game status from the stored board. Once a game
// ends (win or draw) the board and turn freeze until reset.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous active-low reset
//   enable     in   1  move strobe
//   data_in_x  in   2  column of move (0..2)
//   data_in_y  in   2  row of move (0..2)
//   player     in   2  id of moving player (0 or 1)
//   winner     out  2  0 = p0 won, 1 = p1 won, 2 = in progress, 3 = draw
//   stop_game  out  1  game over (win or draw)
// ---------------------------------------------------------------------------
module tttv2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] data_in_x,
  input  logic [1:0] data_in_y,
  input  logic [1:0] player,
  output logic [1:0] winner,
  output logic       stop_game
);

  typedef enum logic [1:0] {
    CELL_P0    = 2'd0,
    CELL_P1    = 2'd1,
    CELL_EMPTY = 2'd3
  } cell_e;

  typedef enum logic [1:0] {
    ST_P0_WIN      = 2'd0,
    ST_P1_WIN      = 2'd1,
    ST_IN_PROGRESS = 2'd2,
    ST_DRAW        = 2'd3
  } status_e;

  // Board indexed [row][col]; the name game_state is observed externally.
  logic [1:0] game_state   [0:2][0:2];
  logic [1:0] game_state_d [0:2][0:2];
  logic       turn_q;
  logic       turn_d;

  logic       coords_ok;
  logic       player_ok;
  logic       cell_empty;
  logic       accept;

  logic       p0_win;
  logic       p1_win;
  logic       board_full;
  status_e    status;

  function automatic logic line_owned(input logic [1:0] a,
                                      input logic [1:0] b,
                                      input logic [1:0] c,
                                      input logic [1:0] p);
    return (a == p) && (b == p) && (c == p);
  endfunction

  function automatic logic any_line(input logic [1:0] p,
                                    input logic [1:0] gs [0:2][0:2]);
    return line_owned(gs[0][0], gs[0][1], gs[0][2], p) ||
           line_owned(gs[1][0], gs[1][1], gs[1][2], p) ||
           line_owned(gs[2][0], gs[2][1], gs[2][2], p) ||
           line_owned(gs[0][0], gs[1][0], gs[2][0], p) ||
           line_owned(gs[0][1], gs[1][1], gs[2][1], p) ||
           line_owned(gs[0][2], gs[1][2], gs[2][2], p) ||
           line_owned(gs[0][0], gs[1][1], gs[2][2], p) ||
           line_owned(gs[0][2], gs[1][1], gs[2][0], p);
  endfunction

  // ---------------------------------------------------------------------
  // Status decode, purely combinational from the stored board.
  // Player 0 is checked first, then player 1, and a win beats a full board.
  // ---------------------------------------------------------------------
  always_comb begin
    p0_win     = any_line(CELL_P0, game_state);
    p1_win     = any_line(CELL_P1, game_state);
    board_full = (game_state[0][0] != CELL_EMPTY) &&
                 (game_state[0][1] != CELL_EMPTY) &&
                 (game_state[0][2] != CELL_EMPTY) &&
                 (game_state[1][0] != CELL_EMPTY) &&
                 (game_state[1][1] != CELL_EMPTY) &&
                 (game_state[1][2] != CELL_EMPTY) &&
                 (game_state[2][0] != CELL_EMPTY) &&
                 (game_state[2][1] != CELL_EMPTY) &&
                 (game_state[2][2] != CELL_EMPTY);

    status = ST_IN_PROGRESS;
    if (p0_win) begin
      status = ST_P0_WIN;
    end else if (p1_win) begin
      status = ST_P1_WIN;
    end else if (board_full) begin
      status = ST_DRAW;
    end
  end

  assign winner    = status;
  assign stop_game = (status != ST_IN_PROGRESS);

  // ---------------------------------------------------------------------
  // Move legality and next-state
  // ---------------------------------------------------------------------
  always_comb begin
    coords_ok = (data_in_x <= 2'd2) && (data_in_y <= 2'd2);
    // Matching the 1-bit turn zero-extended also rules out player ids 2..3.
    player_ok = (player == {1'b0, turn_q});
    // The cell read is only meaningful with in-range coordinates.
    cell_empty = coords_ok && (game_state[data_in_y][data_in_x] == CELL_EMPTY);
    accept     = enable && !stop_game && coords_ok && player_ok && cell_empty;

    game_state_d = game_state;
    turn_d       = turn_q;
    if (accept) begin
      game_state_d[data_in_y][data_in_x] = player;
      turn_d                             = ~turn_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_state <= '{default: CELL_EMPTY};
      turn_q     <= 1'b0;
    end else begin
      game_state <= game_state_d;
      turn_q     <= turn_d;
    end
  end

endmodule

// File: tb/tb_tttv2.sv
module tb_tttv2;

  localparam logic [1:0] E = 2'd3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] data_in_x;
  logic [1:0] data_in_y;
  logic [1:0] player;
  logic [1:0] winner;
  logic       stop_game;

  int checks;
  int fails;

  tttv2 dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_in_x (data_in_x),
    .data_in_y (data_in_y),
    .player    (player),
    .winner    (winner),
    .stop_game (stop_game)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board flattened row-major: {r0c0, r0c1, r0c2, r1c0, ..., r2c2}
  function automatic logic [17:0] board_vec();
    return {dut.game_state[0][0], dut.game_state[0][1], dut.game_state[0][2],
            dut.game_state[1][0], dut.game_state[1][1], dut.game_state[1][2],
            dut.game_state[2][0], dut.game_state[2][1], dut.game_state[2][2]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic move(input logic [1:0] p, input logic [1:0] x,
                      input logic [1:0] y, input logic en);
    @(negedge clk);
    player    = p;
    data_in_x = x;
    data_in_y = y;
    enable    = en;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (board_vec() !== 18'h3FFFF) begin
      fails++;
      $display("FAIL reset_board: got %h expected %h", board_vec(), 18'h3FFFF);
    end
    checks++;
    if (winner !== 2'd2) begin
      fails++;
      $display("FAIL reset_winner: got %0d expected 2", winner);
    end
    checks++;
    if (stop_game !== 1'b0) begin
      fails++;
      $display("FAIL reset_stop: got %0d expected 0", stop_game);
    end
  endtask

  task automatic test_column_win();
    logic [17:0] exp_b;
    do_reset();
    move(2'd0, 2'd0, 2'd0, 1'b1);
    move(2'd1, 2'd1, 2'd0, 1'b1);
    move(2'd0, 2'd0, 2'd1, 1'b1);
    move(2'd1, 2'd1, 2'd1, 1'b1);
    checks++;
    if (winner !== 2'd2 || stop_game !== 1'b0) begin
      fails++;
      $display("FAIL colwin_pre: got winner=%0d stop=%0d expected 2/0", winner, stop_game);
    end
    move(2'd0, 2'd0, 2'd2, 1'b1);
    exp_b = {2'd0, 2'd1, E, 2'd0, 2'd1, E, 2'd0, E, E};
    checks++;
    if (board_vec() !== exp_b) begin
      fails++;
      $display("FAIL colwin_board: got %h expected %h", board_vec(), exp_b);
    end
    checks++;
    if (winner !== 2'd0 || stop_game !== 1'b1) begin
      fails++;
      $display("FAIL colwin_status: got winner=%0d stop=%0d expected 0/1", winner, stop_game);
    end
  endtask

  // Runs directly after test_column_win: board is frozen, turn is player 1.
  task automatic test_frozen();
    move(2'd1, 2'd2, 2'd2, 1'b1);
    checks++;
    if (dut.game_state[2][2] !== E) begin
      fails++;
      $display("FAIL frozen_cell: got %0d expected 3", dut.game_state[2][2]);
    end
    checks++;
    if (winner !== 2'd0 || stop_game !== 1'b1) begin
      fails++;
      $display("FAIL frozen_status: got winner=%0d stop=%0d expected 0/1", winner, stop_game);
    end
  endtask

  task automatic test_diagonal_win();
    logic [17:0] exp_b;
    do_reset();
    move(2'd0, 2'd0, 2'd1, 1'b1);
    move(2'd1, 2'd0, 2'd0, 1'b1);
    move(2'd0, 2'd1, 2'd0, 1'b1);
    move(2'd1, 2'd1, 2'd1, 1'b1);
    move(2'd0, 2'd2, 2'd0, 1'b1);
    checks++;
    if (winner !== 2'd2 || stop_game !== 1'b0) begin
      fails++;
      $display("FAIL diag_pre: got winner=%0d stop=%0d expected 2/0", winner, stop_game);
    end
    move(2'd1, 2'd2, 2'd2, 1'b1);
    exp_b = {2'd1, 2'd0, 2'd0, 2'd0, 2'd1, E, E, E, 2'd1};
    checks++;
    if (board_vec() !== exp_b) begin
      fails++;
      $display("FAIL diag_board: got %h expected %h", board_vec(), exp_b);
    end
    checks++;
    if (winner !== 2'd1 || stop_game !== 1'b1) begin
      fails++;
      $display("FAIL diag_status: got winner=%0d stop=%0d expected 1/1", winner, stop_game);
    end
  endtask

  task automatic test_draw();
    logic [17:0] exp_b;
    do_reset();
    move(2'd0, 2'd0, 2'd0, 1'b1);
    move(2'd1, 2'd1, 2'd0, 1'b1);
    move(2'd0, 2'd2, 2'd0, 1'b1);
    move(2'd1, 2'd0, 2'd1, 1'b1);
    move(2'd0, 2'd2, 2'd1, 1'b1);
    move(2'd1, 2'd1, 2'd1, 1'b1);
    move(2'd0, 2'd0, 2'd2, 1'b1);
    move(2'd1, 2'd2, 2'd2, 1'b1);
    checks++;
    if (winner !== 2'd2 || stop_game !== 1'b0) begin
      fails++;
      $display("FAIL draw_pre: got winner=%0d stop=%0d expected 2/0", winner, stop_game);
    end
    move(2'd0, 2'd1, 2'd2, 1'b1);
    exp_b = {2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    checks++;
    if (board_vec() !== exp_b) begin
      fails++;
      $display("FAIL draw_board: got %h expected %h", board_vec(), exp_b);
    end
    checks++;
    if (winner !== 2'd3 || stop_game !== 1'b1) begin
      fails++;
      $display("FAIL draw_status: got winner=%0d stop=%0d expected 3/1", winner, stop_game);
    end
  endtask

  task automatic test_illegal();
    logic [17:0] exp_b;
    do_reset();
    exp_b = 18'h3FFFF;
    // player 1 first, enable low, player id 2, x=3, y=3: all rejected
    move(2'd1, 2'd0, 2'd0, 1'b1);
    checks++;
    if (board_vec() !== exp_b || winner !== 2'd2) begin
      fails++;
      $display("FAIL illegal_p1_first: got %h/%0d expected %h/2", board_vec(), winner, exp_b);
    end
    move(2'd0, 2'd0, 2'd0, 1'b0);
    checks++;
    if (board_vec() !== exp_b || winner !== 2'd2) begin
      fails++;
      $display("FAIL illegal_enable_low: got %h/%0d expected %h/2", board_vec(), winner, exp_b);
    end
    move(2'd2, 2'd0, 2'd0, 1'b1);
    checks++;
    if (board_vec() !== exp_b || winner !== 2'd2) begin
      fails++;
      $display("FAIL illegal_player2: got %h/%0d expected %h/2", board_vec(), winner, exp_b);
    end
    move(2'd0, 2'd3, 2'd0, 1'b1);
    checks++;
    if (board_vec() !== exp_b || winner !== 2'd2) begin
      fails++;
      $display("FAIL illegal_x3: got %h/%0d expected %h/2", board_vec(), winner, exp_b);
    end
    move(2'd0, 2'd0, 2'd3, 1'b1);
    checks++;
    if (board_vec() !== exp_b || winner !== 2'd2) begin
      fails++;
      $display("FAIL illegal_y3: got %h/%0d expected %h/2", board_vec(), winner, exp_b);
    end
    // turn still 0: player 0 centre is accepted
    move(2'd0, 2'd1, 2'd1, 1'b1);
    exp_b = {E, E, E, E, 2'd0, E, E, E, E};
    checks++;
    if (board_vec() !== exp_b) begin
      fails++;
      $display("FAIL legal_centre: got %h expected %h", board_vec(), exp_b);
    end
    // player 1 onto occupied centre: rejected
    move(2'd1, 2'd1, 2'd1, 1'b1);
    checks++;
    if (board_vec() !== exp_b || winner !== 2'd2) begin
      fails++;
      $display("FAIL illegal_occupied: got %h/%0d expected %h/2", board_vec(), winner, exp_b);
    end
    // player 0 out of turn: rejected
    move(2'd0, 2'd0, 2'd0, 1'b1);
    checks++;
    if (board_vec() !== exp_b) begin
      fails++;
      $display("FAIL illegal_out_of_turn: got %h expected %h", board_vec(), exp_b);
    end
    // turn still 1 after all rejections: player 1 accepted
    move(2'd1, 2'd0, 2'd0, 1'b1);
    exp_b = {2'd1, E, E, E, 2'd0, E, E, E, E};
    checks++;
    if (board_vec() !== exp_b) begin
      fails++;
      $display("FAIL turn_kept: got %h expected %h", board_vec(), exp_b);
    end
  endtask

  task automatic test_async_reset();
    logic [17:0] exp_b;
    do_reset();
    move(2'd0, 2'd0, 2'd0, 1'b1);
    move(2'd1, 2'd1, 2'd0, 1'b1);
    // assert reset between edges and observe before any rising edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (board_vec() !== 18'h3FFFF || winner !== 2'd2 || stop_game !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got %h/%0d/%0d expected 3ffff/2/0",
               board_vec(), winner, stop_game);
    end
    @(negedge clk);
    reset = 1'b1;
    move(2'd0, 2'd2, 2'd2, 1'b1);
    exp_b = {E, E, E, E, E, E, E, E, 2'd0};
    checks++;
    if (board_vec() !== exp_b) begin
      fails++;
      $display("FAIL after_async_reset: got %h expected %h", board_vec(), exp_b);
    end
  endtask

  task automatic test_reset_after_draw();
    test_draw();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (stop_game !== 1'b0 || winner !== 2'd2 || board_vec() !== 18'h3FFFF) begin
      fails++;
      $display("FAIL reset_after_draw: got %h/%0d/%0d expected 3ffff/2/0",
               board_vec(), winner, stop_game);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    reset     = 1'b0;
    enable    = 1'b0;
    data_in_x = 2'd0;
    data_in_y = 2'd0;
    player    = 2'd0;

    test_reset();
    test_column_win();
    test_frozen();
    test_diagonal_win();
    test_draw();
    test_illegal();
    test_async_reset();
    test_reset_after_draw();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tttv2.md
Name: tttv2

Overview:
- Single-board tic-tac-toe (3x3) referee.
- Accepts one move per clock from an external player source, stores the board and enforces legal moves and turn order.
- Continuously reports the winner / draw status and freezes the board when the game ends.
- Sits between a move-entry front end (or testbench) and any display/score logic.

Parameters:
- None. Board size is fixed at 3x3; cell and status encodings are fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  move strobe; a move is considered only on rising edges where enable=1.
- data_in_x  input  2  column index of move (0..2); value 3 is illegal.
- data_in_y  input  2  row index of move (0..2); value 3 is illegal.
- player  input  2  id of the player making the move: 0 or 1; values 2..3 are illegal.
- winner  output  2  game status: 0 = player 0 won, 1 = player 1 won, 2 = game in progress, 3 = draw.
- stop_game  output  1  1 when the game is over (win or draw), else 0.

Behaviour:
- Internal board game_state[row][col], 3x3 array of 2-bit cells, row = data_in_y, col = data_in_x. The name game_state is fixed; verification probes it hierarchically.
- Cell encoding: 0 = player 0, 1 = player 1, 3 = empty; 2 is never stored.
- Internal turn register: holds the player expected to move next. Reset value 0, so player 0 always moves first.
- Reset (reset=0, asynchronous):
  - all cells = 3 (empty); turn = 0.
  - winner = 2; stop_game = 0.
- A move is accepted on a rising edge only if all of the following hold:
  - reset=1 and enable=1;
  - stop_game=0;
  - data_in_x<=2 and data_in_y<=2;
  - player<=1 and player==turn;
  - the target cell is empty (3).
- Accepted move: game_state[y][x] <= player; turn toggles. Updates complete at the same edge; 1-cycle latency for the board.
- Rejected move: no state change at all, no error flag; turn is unchanged.
- Status decode is combinational from the registered board, so winner and stop_game are valid in the same cycle the board updates, no extra cycle:
  - Win: any of the 8 lines (3 rows, 3 columns, 2 diagonals) whose three cells are equal and non-empty. winner = that cell value.
  - Draw: no winning line and all 9 cells non-empty. winner = 3.
  - Otherwise winner = 2.
  - stop_game = (winner != 2).
- Priority: a completed line beats a full board. A ninth move that completes a line reports a win, not a draw.
- Two simultaneous winning lines are impossible under enforced alternation. If they occur, the player-0 check takes precedence.
- Once stop_game=1, the board and turn freeze and all moves are ignored until reset.
- Reset mid-game clears everything immediately, independent of clk.
- enable=0 holds all state; outputs remain a function of the stored board.

Test Plan:
- Column win, player 0. After reset, enable=1, moves (p,x,y): (0,0,0),(1,1,0),(0,0,1),(1,1,1),(0,0,2), one per cycle. Required after the 5th edge: game_state[0][0]=game_state[1][0]=game_state[2][0]=0, winner=0, stop_game=1.
- Diagonal win, player 1. After reset, moves (0,0,1),(1,0,0),(0,1,0),(1,1,1),(0,2,0),(1,2,2). Required: winner=1 after the 6th edge, stop_game=1.
- Draw. After reset, moves (0,0,0),(1,1,0),(0,2,0),(1,0,1),(0,2,1),(1,1,1),(0,0,2),(1,2,2),(0,1,2). Required: rows read 0 1 0 / 1 1 0 / 0 0 1, winner=3, stop_game=1. Before the 9th move: winner=2, stop_game=0.
- Illegal moves. Each of these leaves the board and turn unchanged and winner=2:
  - a move to an occupied cell;
  - x=3 or y=3;
  - player=2;
  - player 1 moving first after reset;
  - any move with enable=0.
- Frozen after win. After the column-win sequence, apply player 1 move (1,2,2). Required: game_state[2][2] remains 3, winner stays 0.
- Asynchronous reset. Drive reset=0 mid-game between clock edges. Required: all cells read 3, winner=2, stop_game=0 immediately; the next move by player 0 is accepted.
